// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: data width, arbiter states, master indices.
package dmem_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_LOCK1 = 1'b1
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-way round-robin pick; on a tie the master not granted last wins.
// Latency: pick is combinational; the last-grant pointer updates at the clock edge.
// Backpressure: none; a master that is not picked simply keeps requesting.
module dmem_arb_rr2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] gnt,
    output logic [1:0] pick
);

    logic last_gnt;

    // Reset points at the DMA side so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= M_DMA;
        end else if (gnt[M_CPU]) begin
            last_gnt <= M_CPU;
        end else if (gnt[M_DMA]) begin
            last_gnt <= M_DMA;
        end
    end

    always_comb begin
        pick = req;
        if (req[M_CPU] && req[M_DMA]) begin
            pick = '0;
            if (last_gnt == M_DMA) begin
                pick[M_CPU] = 1'b1;
            end else begin
                pick[M_DMA] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU (m0) and DMA (m1); DMEM_ARB_STATS_EN adds stat counters.
// Latency: grant and memory drive are combinational; read data is registered, rvalid one cycle after gnt.
// Backpressure: a master holds its request until gnt; m1 may lock the port, bounded by MAX_BURST.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic [ADDR_W-1:0] dmem_a,
    output logic [DATA_W-1:0] dmem_wd,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_conflict,
    output logic [15:0]       stat_starve
`endif
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    arb_state_t state, state_nxt;
    logic [7:0] burst_cnt, burst_nxt;
    logic [1:0] rr_pick;
    logic [1:0] gnt;
    logic       force_m0;

    dmem_arb_rr2 u_rr2 (
        .clk  (clk),
        .rst  (rst),
        .req  ({m1_req, m0_req}),
        .gnt  (gnt),
        .pick (rr_pick)
    );

    // m1 has held the port for MAX_BURST beats while m0 waited: give m0 one beat.
    assign force_m0 = (state == ARB_LOCK1) && m1_req && m0_req && (burst_cnt == MAX_BURST_C);

    always_comb begin
        gnt       = '0;
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            ARB_IDLE: begin
                gnt = rr_pick;
                if (gnt[M_DMA] && m1_lock) begin
                    state_nxt = ARB_LOCK1;
                end
            end
            ARB_LOCK1: begin
                if (force_m0) begin
                    gnt[M_CPU] = 1'b1;
                end else if (m1_req) begin
                    gnt[M_DMA] = 1'b1;
                    if (!m1_lock) begin
                        state_nxt = ARB_IDLE;
                    end
                end else begin
                    gnt[M_CPU] = m0_req;
                    state_nxt  = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (gnt[M_CPU] || state_nxt == ARB_IDLE) begin
            burst_nxt = '0;
        end else if (gnt[M_DMA] && m0_req) begin
            burst_nxt = burst_cnt + 8'd1;
        end
        if (rst) begin
            gnt = '0;
        end
    end

    assign m0_gnt = gnt[M_CPU];
    assign m1_gnt = gnt[M_DMA];

    always_comb begin
        dmem_a  = '0;
        dmem_wd = '0;
        dmem_we = 1'b0;
        if (gnt[M_CPU]) begin
            dmem_a  = m0_addr;
            dmem_wd = m0_wd;
            dmem_we = m0_we;
        end else if (gnt[M_DMA]) begin
            dmem_a  = m1_addr;
            dmem_wd = m1_wd;
            dmem_we = m1_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rd     <= '0;
            m1_rd     <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            m0_rvalid <= gnt[M_CPU] && !m0_we;
            m1_rvalid <= gnt[M_DMA] && !m1_we;
            if (gnt[M_CPU] && !m0_we) begin
                m0_rd <= dmem_rd;
            end
            if (gnt[M_DMA] && !m1_we) begin
                m1_rd <= dmem_rd;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflict <= '0;
            stat_starve   <= '0;
        end else begin
            if (m0_req && m1_req && stat_conflict != '1) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
            if (force_m0 && stat_starve != '1) begin
                stat_starve <= stat_starve + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus hand sequences, read data checked through a scoreboard.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 16;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic load = 1'b1;
    always #5 clk = ~clk;

    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0]     m0_addr = '0;
    logic [DATA_W-1:0] m0_wd = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [AW-1:0]     m1_addr = '0;
    logic [DATA_W-1:0] m1_wd = '0;

    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, dmem_we;
    logic [DATA_W-1:0] m0_rd, m1_rd, dmem_wd, dmem_rd;
    logic [AW-1:0]     dmem_a;

    logic              b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_dmem_we;
    logic [DATA_W-1:0] b_m0_rd, b_m1_rd, b_dmem_wd;
    logic [AW-1:0]     b_dmem_a;
    logic [DATA_W-1:0] b_dmem_rd = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_conflict, b_stat_conflict;
    logic [15:0] stat_starve, b_stat_starve;
`endif

    dmem_arbiter #(.ADDR_W(AW), .MAX_BURST(8)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
        .dmem_a(dmem_a), .dmem_wd(dmem_wd), .dmem_we(dmem_we), .dmem_rd(dmem_rd)
`ifdef DMEM_ARB_STATS_EN
        , .stat_conflict(stat_conflict), .stat_starve(stat_starve)
`endif
    );

    // Second instance with a short burst bound, sharing the request stimulus.
    dmem_arbiter #(.ADDR_W(AW), .MAX_BURST(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rd(b_m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_lock(m1_lock),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rd(b_m1_rd),
        .dmem_a(b_dmem_a), .dmem_wd(b_dmem_wd), .dmem_we(b_dmem_we), .dmem_rd(b_dmem_rd)
`ifdef DMEM_ARB_STATS_EN
        , .stat_conflict(b_stat_conflict), .stat_starve(b_stat_starve)
`endif
    );

    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] ref_mem [256];

    function automatic logic [DATA_W-1:0] init_val(input int i);
        return 32'h01020100 + 32'(2 * i);
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (dmem_we) begin
            mem[dmem_a[7:0]] <= dmem_wd;
        end
    end
    assign dmem_rd = mem[dmem_a[7:0]];

    typedef struct {
        logic              rst;
        logic              r0, we0;
        logic [AW-1:0]     a0;
        logic [DATA_W-1:0] wd0;
        logic              r1, we1;
        logic [AW-1:0]     a1;
        logic [DATA_W-1:0] wd1;
        logic              lk;
        logic              g0, g1;
        logic              cb, b0, b1;
    } vec_t;

    vec_t tbl[$];

    int n_chk = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] q0[$], q1[$];
    logic              pend0 = 1'b0, pend1 = 1'b0;
    logic [DATA_W-1:0] hold0 = '0, hold1 = '0;

    function automatic vec_t mk(input logic rst, input logic r0, input logic we0, input int a0,
                                input logic [DATA_W-1:0] wd0, input logic r1, input logic we1,
                                input int a1, input logic [DATA_W-1:0] wd1, input logic lk,
                                input logic g0, input logic g1, input logic cb = 1'b0,
                                input logic b0 = 1'b0, input logic b1 = 1'b0);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.we0 = we0; v.a0 = AW'(a0); v.wd0 = wd0;
        v.r1 = r1; v.we1 = we1; v.a1 = AW'(a1); v.wd1 = wd1; v.lk = lk;
        v.g0 = g0; v.g1 = g1; v.cb = cb; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rv();
        chk("m0_rvalid", 64'(m0_rvalid), 64'(pend0));
        if (pend0) hold0 = q0.pop_front();
        chk("m0_rd", 64'(m0_rd), 64'(hold0));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(pend1));
        if (pend1) hold1 = q1.pop_front();
        chk("m1_rd", 64'(m1_rd), 64'(hold1));
        pend0 = 1'b0;
        pend1 = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        logic [AW-1:0]     ea;
        logic [DATA_W-1:0] ewd;
        logic              ewe;
        @(negedge clk);
        check_rv();
        rst = v.rst;
        m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wd = v.wd0;
        m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wd = v.wd1; m1_lock = v.lk;
        #1;
        chk("m0_gnt", 64'(m0_gnt), 64'(v.g0));
        chk("m1_gnt", 64'(m1_gnt), 64'(v.g1));
        ea = '0; ewd = '0; ewe = 1'b0;
        if (v.g0) begin
            ea = v.a0; ewd = v.wd0; ewe = v.we0;
        end else if (v.g1) begin
            ea = v.a1; ewd = v.wd1; ewe = v.we1;
        end
        chk("dmem_a", 64'(dmem_a), 64'(ea));
        chk("dmem_wd", 64'(dmem_wd), 64'(ewd));
        chk("dmem_we", 64'(dmem_we), 64'(ewe));
        if (v.cb) begin
            chk("b_m0_gnt", 64'(b_m0_gnt), 64'(v.b0));
            chk("b_m1_gnt", 64'(b_m1_gnt), 64'(v.b1));
        end
        if (v.rst) begin
            hold0 = '0;
            hold1 = '0;
        end
        if (v.g0) begin
            if (v.we0) ref_mem[v.a0[7:0]] = v.wd0;
            else begin q0.push_back(ref_mem[v.a0[7:0]]); pend0 = 1'b1; end
        end
        if (v.g1) begin
            if (v.we1) ref_mem[v.a1[7:0]] = v.wd1;
            else begin q1.push_back(ref_mem[v.a1[7:0]]); pend1 = 1'b1; end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        // reset, tie alternation, single reads, plain writes, locked burst
        tbl.push_back(mk(1, 1,0,2,0,  1,0,5,0,0,  0,0));
        tbl.push_back(mk(0, 1,0,2,0,  1,0,3,0,0,  1,0));
        tbl.push_back(mk(0, 1,0,4,0,  1,0,3,0,0,  0,1));
        tbl.push_back(mk(0, 1,0,4,0,  1,0,6,0,0,  1,0));
        tbl.push_back(mk(0, 1,0,7,0,  1,0,6,0,0,  0,1));
        tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));
        tbl.push_back(mk(0, 1,0,2,0,  0,0,0,0,0,  1,0));
        tbl.push_back(mk(0, 0,0,0,0,  1,0,9,0,0,  0,1));
        tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));
        tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));
        tbl.push_back(mk(0, 1,1,10,32'hAAAA0001, 0,0,0,0,0, 1,0));
        tbl.push_back(mk(0, 0,0,0,0,  1,0,10,0,0, 0,1));
        tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));
        tbl.push_back(mk(0, 1,0,20,0, 0,0,0,0,0,  1,0));
        tbl.push_back(mk(0, 1,0,21,0, 1,1,0,32'hD0D00000,1, 0,1));
        tbl.push_back(mk(0, 1,0,21,0, 1,1,1,32'hD0D00001,1, 0,1));
        tbl.push_back(mk(0, 1,0,21,0, 1,1,2,32'hD0D00002,1, 0,1));
        tbl.push_back(mk(0, 1,0,21,0, 1,1,3,32'hD0D00003,0, 0,1));
        tbl.push_back(mk(0, 1,0,21,0, 1,0,5,0,0,  1,0));
        tbl.push_back(mk(0, 1,0,0,0,  1,0,5,0,0,  0,1));
        tbl.push_back(mk(0, 1,0,0,0,  1,0,3,0,0,  1,0));
        tbl.push_back(mk(0, 0,0,0,0,  1,0,3,0,0,  0,1));
        tbl.push_back(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));

        @(posedge clk);
        #1 load = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        for (int i = 0; i < 4; i++) chk("mem_after_lock", 64'(mem[i]), 64'(ref_mem[i]));

        // abandon: m1 drops req while locked, m0 takes the beat, arbitration resumes
        apply(mk(0, 0,0,0,0,  1,1,30,32'hBEEF0030,1, 0,1));
        apply(mk(0, 1,0,31,0, 0,0,0,0,0,  1,0));
        apply(mk(0, 1,0,32,0, 1,0,30,0,0, 0,1));
        apply(mk(0, 1,0,32,0, 1,0,33,0,0, 1,0));

        // reset while m1 holds the lock with reads pending
        apply(mk(0, 0,0,0,0,  1,1,40,32'hC0DE0040,1, 0,1));
        apply(mk(0, 0,0,0,0,  1,1,41,32'hC0DE0041,1, 0,1));
        apply(mk(1, 1,0,43,0, 1,0,42,0,1, 0,0));
        apply(mk(0, 1,0,43,0, 1,0,42,0,1, 1,0));
        apply(mk(0, 0,0,0,0,  1,0,42,0,0, 0,1));
        apply(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));

        // starvation bound: MAX_BURST=2 instance forces m0 every third beat, MAX_BURST=8 does not
        apply(mk(1, 0,0,0,0,  0,0,0,0,0,  0,0, 1,0,0));
        apply(mk(0, 0,0,0,0,  1,1,50,32'h5A5A0050,1, 0,1, 1,0,1));
        for (int k = 0; k < 6; k++) begin
            logic bf;
            bf = (k % 3 == 2);
            apply(mk(0, 1,0,60,0, 1,1,50,32'h5A5A0050,1, 0,1, 1,bf,!bf));
        end
        apply(mk(0, 1,0,60,0, 1,1,50,32'h5A5A0050,0, 0,1, 1,0,1));
        apply(mk(0, 1,0,60,0, 0,0,0,0,0,  1,0, 1,1,0));
        apply(mk(0, 0,0,0,0,  0,0,0,0,0,  0,0));

`ifdef DMEM_ARB_STATS_EN
        chk("b_stat_starve", 64'(b_stat_starve), 64'd2);
        chk("stat_starve", 64'(stat_starve), 64'd0);
        chk("stat_conflict", 64'(stat_conflict), 64'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (`dmem`, 16-bit word address, `DATA_W` data, asynchronous read, write on clk rising edge) between two requesters:
  - m0: CPU load/store unit.
  - m1: DMA/host loader, which streams initial tables into memory and reads results out.
- Arbitration: round-robin, with burst locking for m1 and a starvation bound.
- Drives the dmem `a`/`wd`/`we` pins directly.
- Registers read data so each master sees a fixed one-cycle read latency.

Parameters:
- ADDR_W, 16, word address width; matches the dmem `a` port.
- MAX_BURST, 8, maximum consecutive m1 grants while m0 is waiting; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write (1) / read (0).
- m0_addr  in  ADDR_W  m0 word address.
- m0_wd  in  DATA_W  m0 write data.
- m0_gnt  out  1  m0 access performed this cycle.
- m0_rvalid  out  1  m0 read data valid.
- m0_rd  out  DATA_W  m0 read data.
- m1_req, m1_we, m1_addr, m1_wd  in  same meanings for m1.
- m1_lock  in  1  m1 requests to keep ownership after this beat.
- m1_gnt, m1_rvalid, m1_rd  out  same meanings for m1.
- dmem_a  out  ADDR_W  to dmem `a`.
- dmem_wd  out  DATA_W  to dmem `wd`.
- dmem_we  out  1  to dmem `we`.
- dmem_rd  in  DATA_W  from dmem `rd`.

Behaviour:
- Grant timing
  - Grants are combinational in the request cycle; at most one gnt is high per cycle.
  - A granted write commits at the next clk edge.
  - A granted read samples dmem_rd into the master's rd register at that edge. mX_rvalid is 1 for exactly the following cycle.
  - mX_rd holds its value until the next read by that master.
- Memory-side drive
  - dmem_a, dmem_wd and dmem_we are muxed from the granted master.
  - With no grant: dmem_we=0, dmem_a=0, dmem_wd=0.
- Handshake
  - A master holds req, addr, we and wd stable until it sees gnt.
  - Dropping req without gnt is legal; the access is abandoned.
- States
  - IDLE/RR: no owner.
    - Single requester: granted.
    - Both requesting: grant the master not granted last (last_gnt pointer).
    - A granted m1 beat with m1_lock=1 → LOCK1.
  - LOCK1: m1 owns the port.
    - m1_req=1: m1 granted. If m1_lock=0 on that beat → IDLE.
    - m1_req=0: no grant; a waiting m0 is granted instead and the state returns to IDLE (lock released).
    - Starvation bound: burst_cnt counts consecutive m1 grants while m0_req=1. When burst_cnt=MAX_BURST and m0_req=1, m0 is granted that cycle, burst_cnt clears, and the state stays LOCK1.
    - burst_cnt clears whenever m0 is granted or the state returns to IDLE.
- Reset
  - State=IDLE, last_gnt=m1 (so m0 wins the first tie), burst_cnt=0.
  - m0_rvalid=m1_rvalid=0; m0_rd=m1_rd=0.
  - All gnt outputs are 0 while rst=1, and dmem_we=0.
  - A read granted in the cycle rst rises produces no rvalid.
  - Reset mid-lock releases the lock.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output stat_conflict[31:0]: cycles where both req were high.
  - Adds output stat_starve[15:0]: forced m0 grants.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (def.h) holds:
  - `DATA_W`.
  - Arbiter state encodings ARB_IDLE / ARB_LOCK1.
  - Master index constants M_CPU=0, M_DMA=1.
- One natural sub-module: dmem_arb_rr2, the two-way round-robin pick with last_gnt pointer (purely combinational pick plus pointer flop).
- Read-data registers and the dmem mux stay in the top.

Test Plan:
- Single read: m0 read addr 2 with mem[2]=32'h01020104 → m0_gnt same cycle; next cycle m0_rvalid=1, m0_rd=32'h01020104.
- Tie: m0 and m1 request reads continuously from reset → grants alternate m0,m1,m0,…; no cycle has both gnt high.
- Lock: m1 writes addrs 0..3 with lock=1,1,1,0 while m0 requests → m1 granted 4 consecutive cycles, then m0 granted; mem[0..3] hold the written data.
- Starvation: MAX_BURST=2, m1 locks indefinitely, m0 requests → grant pattern m1,m1,m0,m1,m1,m0; stat_starve increments per forced grant (when DMEM_ARB_STATS_EN is defined).
- Reset mid-lock: assert rst during LOCK1 with a pending read → that cycle has no gnt and dmem_we=0; no rvalid follows; after release, m0 wins the first tie.
- Abandon: m1_req drops while locked and m0 waits → m0 granted that cycle, state IDLE; a subsequent m1 request is arbitrated normally.
